de2_70_onchip_memory_pipe: RTL and testbench

- Parametrised Avalon-MM on-chip RAM slave for the Nios II system. Successor to the fixed 1024x32 single-port on-chip memory.
- Generalises data width and depth, and adds explicit read/readdatavalid/waitrequest handshakes.
- Adds a selectable 1- or 2-cycle read pipeline.
- Adds an optional post-reset clear sequencer.
- Sits on the Qsys interconnect as a pipelined slave with variable latency.

---
 rtl/de2_70_onchip_memory_pipe.sv | 166 ++++++++++++++++
 tb/tb_de2_70_onchip_memory_pipe.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/de2_70_onchip_memory_pipe.sv
// -----------------------------------------------------------------------------
// de2_70_onchip_memory_pipe
//
// Parametrised single-port on-chip RAM presented as a pipelined Avalon-MM
// slave with variable latency (read / readdatavalid / waitrequest).
//
// Parameters
//   DATA_WIDTH   : word width in bits, multiple of 8
//   ADDR_WIDTH   : word address bits, depth = 2**ADDR_WIDTH
//   READ_LATENCY : 1 = array output only, 2 = extra output register stage
//   INIT_FILE    : power-up image name handed to the FPGA memory
//                  initialisation flow; the RTL itself never loads it
//
// Optional feature (compile-time macro ONCHIP_MEM_CLEAR_EN)
//   Defined     : after reset a CLEAR sequencer zeroes every word, one word
//                 per enabled cycle, with waitrequest held high throughout.
//   Not defined : no clear sequencer; the slave is ready straight out of reset
//                 and the array keeps its previous contents.
//
// Ports
//   clk, reset_n   : rising-edge clock, asynchronous active-low reset
//   clken          : clock enable; low freezes all state
//   chipselect     : slave select
//   address        : word address
//   byteenable     : per-byte write enable
//   read, write    : transfer requests (write wins when both are high)
//   writedata      : write data
//   readdata       : read data, meaningful while readdatavalid is high
//   readdatavalid  : one-cycle pulse per accepted read
//   waitrequest    : slave stall (clearing or clock disabled)
// -----------------------------------------------------------------------------
module de2_70_onchip_memory_pipe #(
  parameter int    DATA_WIDTH   = 32,
  parameter int    ADDR_WIDTH   = 10,
  parameter int    READ_LATENCY = 1,
  parameter string INIT_FILE    = "de2_70_onchip_memory.hex"
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    clken,
  input  logic                    chipselect,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [DATA_WIDTH/8-1:0] byteenable,
  input  logic                    read,
  input  logic                    write,
  input  logic [DATA_WIDTH-1:0]   writedata,
  output logic [DATA_WIDTH-1:0]   readdata,
  output logic                    readdatavalid,
  output logic                    waitrequest
);

  localparam int NUM_BYTES = DATA_WIDTH / 8;
  localparam int DEPTH     = 1 << ADDR_WIDTH;

  // Elaboration-time parameter sanity checks.
  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
    $fatal(1, "de2_70_onchip_memory_pipe: READ_LATENCY=%0d is illegal (image %s)",
           READ_LATENCY, INIT_FILE);
  end
  if (DATA_WIDTH % 8 != 0) begin : g_bad_width
    $fatal(1, "de2_70_onchip_memory_pipe: DATA_WIDTH=%0d is not a multiple of 8",
           DATA_WIDTH);
  end

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_readdata;
  logic                  r_valid_out;
  logic                  w_waitrequest;
  logic                  w_accept;
  logic                  w_wr_accept;
  logic                  w_rd_accept;

`ifdef ONCHIP_MEM_CLEAR_EN
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  state_e                r_state;
  logic [ADDR_WIDTH-1:0] r_clr_addr;

  // A reset asserted mid-clear lands back in CLEAR at address 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_CLEAR;
      r_clr_addr <= '0;
    end else if (clken && r_state == ST_CLEAR) begin
      r_clr_addr <= r_clr_addr + ADDR_WIDTH'(1);
      if (&r_clr_addr) begin
        r_state <= ST_READY;
      end
    end
  end

  assign w_waitrequest = (r_state == ST_CLEAR) | ~clken;
`else
  assign w_waitrequest = ~clken;
`endif

  // Write has priority: a cycle with both read and write is a pure write.
  assign w_accept    = chipselect & ~w_waitrequest;
  assign w_wr_accept = w_accept & write;
  assign w_rd_accept = w_accept & read & ~write;

  // NOTE: the storage array has no reset branch so it can map onto block RAM;
  // contents survive reset and only the pipeline/handshake state is cleared.
  always_ff @(posedge clk) begin
`ifdef ONCHIP_MEM_CLEAR_EN
    if (clken && r_state == ST_CLEAR) begin
      r_mem[r_clr_addr] <= '0;
    end
`endif
    if (w_wr_accept) begin
      for (int b = 0; b < NUM_BYTES; b++) begin
        if (byteenable[b]) begin
          r_mem[address][8*b +: 8] <= writedata[8*b +: 8];
        end
      end
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic [DATA_WIDTH-1:0] r_mem_q;
    logic                  r_valid_s1;

    // Array output register; sampled only on an accepted read edge.
    always_ff @(posedge clk) begin
      if (w_rd_accept) begin
        r_mem_q <= r_mem[address];
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_valid_s1  <= 1'b0;
        r_valid_out <= 1'b0;
        r_readdata  <= '0;
      end else if (clken) begin
        r_valid_s1  <= w_rd_accept;
        r_valid_out <= r_valid_s1;
        if (r_valid_s1) begin
          r_readdata <= r_mem_q;
        end
      end
    end
  end else begin : g_lat1
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_valid_out <= 1'b0;
        r_readdata  <= '0;
      end else if (clken) begin
        r_valid_out <= w_rd_accept;
        if (w_rd_accept) begin
          r_readdata <= r_mem[address];
        end
      end
    end
  end

  // A valid held across a frozen cycle is hidden until clken returns, so each
  // read still produces exactly one visible pulse.
  assign readdata      = r_readdata;
  assign readdatavalid = r_valid_out & clken;
  assign waitrequest   = w_waitrequest;

endmodule

// File: tb/tb_de2_70_onchip_memory_pipe.sv
// -----------------------------------------------------------------------------
// tb_de2_70_onchip_memory_pipe
//
// Drives one shared Avalon-MM bus into two instances of the RAM slave
// (READ_LATENCY=1 and READ_LATENCY=2, 16 words each) and compares both
// against a transaction-level reference: a word array plus a list of
// in-flight reads tagged with the enabled-edge index at which each must appear.
// Builds with or without ONCHIP_MEM_CLEAR_EN.
// -----------------------------------------------------------------------------
module tb_de2_70_onchip_memory_pipe;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;
  localparam int BW    = DW / 8;

`ifdef ONCHIP_MEM_CLEAR_EN
  localparam int CLEAR_WORDS = DEPTH;
`else
  localparam int CLEAR_WORDS = 0;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic          clken;
  logic          chipselect;
  logic [AW-1:0] address;
  logic [BW-1:0] byteenable;
  logic          read;
  logic          write;
  logic [DW-1:0] writedata;

  logic [DW-1:0] rd_data1, rd_data2;
  logic          rd_valid1, rd_valid2;
  logic          wait1, wait2;

  always #5 clk = ~clk;

  de2_70_onchip_memory_pipe #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(1)
  ) u_dut_l1 (
    .clk(clk), .reset_n(reset_n), .clken(clken), .chipselect(chipselect),
    .address(address), .byteenable(byteenable), .read(read), .write(write),
    .writedata(writedata), .readdata(rd_data1), .readdatavalid(rd_valid1),
    .waitrequest(wait1)
  );

  de2_70_onchip_memory_pipe #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(2)
  ) u_dut_l2 (
    .clk(clk), .reset_n(reset_n), .clken(clken), .chipselect(chipselect),
    .address(address), .byteenable(byteenable), .read(read), .write(write),
    .writedata(writedata), .readdata(rd_data2), .readdatavalid(rd_valid2),
    .waitrequest(wait2)
  );

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef struct {
    int          lane;   // 0 -> latency 1 instance, 1 -> latency 2 instance
    int          due;    // enabled-edge index after which the data appears
    logic [DW-1:0] data;
  } flight_t;

  logic [DW-1:0] ref_mem [DEPTH];
  flight_t       fl[$];
  bit            pres [2];
  logic [DW-1:0] hold [2];
  int            ecount;
  int            clear_left;
  int            n_checks;
  int            n_errors;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    fl.delete();
    pres[0] = 1'b0;  pres[1] = 1'b0;
    hold[0] = '0;    hold[1] = '0;
    ecount     = 0;
    clear_left = CLEAR_WORDS;
  endtask

  // Applies the rules of one rising edge to the reference, using the bus
  // values that were presented to the DUTs for that edge.
  task automatic model_edge();
    if (!clken) return;
    ecount++;
    if (clear_left > 0) begin
      ref_mem[DEPTH - clear_left] = '0;
      clear_left--;
    end else if (chipselect) begin
      if (write) begin
        for (int b = 0; b < BW; b++)
          if (byteenable[b]) ref_mem[address][8*b +: 8] = writedata[8*b +: 8];
      end else if (read) begin
        fl.push_back('{lane: 0, due: ecount,     data: ref_mem[address]});
        fl.push_back('{lane: 1, due: ecount + 1, data: ref_mem[address]});
      end
    end
    pres[0] = 1'b0;
    pres[1] = 1'b0;
    foreach (fl[i]) begin
      if (fl[i].due == ecount) begin
        pres[fl[i].lane] = 1'b1;
        hold[fl[i].lane] = fl[i].data;
      end
    end
    for (int i = fl.size() - 1; i >= 0; i--)
      if (fl[i].due <= ecount) fl.delete(i);
  endtask

  task automatic check_outputs();
    logic exp_wait;
    exp_wait = (clear_left > 0) || !clken;
    check("waitreq_l1", DW'(wait1),     DW'(exp_wait));
    check("waitreq_l2", DW'(wait2),     DW'(exp_wait));
    check("valid_l1",   DW'(rd_valid1), DW'(pres[0] && clken));
    check("valid_l2",   DW'(rd_valid2), DW'(pres[1] && clken));
    check("rdata_l1",   rd_data1,       hold[0]);
    check("rdata_l2",   rd_data2,       hold[1]);
  endtask

  // One bus cycle: drive, check the settled outputs, clock, update the model.
  task automatic step(input bit cs, input bit rd, input bit wr, input int a,
                      input int be, input logic [DW-1:0] wd, input bit ce);
    chipselect = cs;
    read       = rd;
    write      = wr;
    address    = AW'(a);
    byteenable = BW'(be);
    writedata  = wd;
    clken      = ce;
    #1;
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 0, 0, '0, 1'b1);
  endtask

  task automatic do_read(input int a);
    step(1'b1, 1'b1, 1'b0, a, 0, '0, 1'b1);
  endtask

  task automatic do_write(input int a, input logic [DW-1:0] d, input int be);
    step(1'b1, 1'b0, 1'b1, a, be, d, 1'b1);
  endtask

  // Reset is asserted between edges so its asynchronous effect is visible
  // before any clock arrives.
  task automatic apply_reset();
    reset_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(posedge clk);
    #1;
    check_outputs();
    reset_n = 1'b1;
  endtask

`ifdef ONCHIP_MEM_CLEAR_EN
  // Counts cycles with waitrequest high after reset release, bounded.
  task automatic measure_clear(input string tag, input int stop_after);
    int cnt;
    cnt = 0;
    for (int i = 0; i < 4 * DEPTH && wait1 && cnt < stop_after; i++) begin
      cnt++;
      idle();
    end
    if (stop_after > DEPTH) check(tag, DW'(cnt), DW'(DEPTH));
  endtask
`endif

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    reset_n    = 1'b0;
    clken      = 1'b1;
    chipselect = 1'b0;
    read       = 1'b0;
    write      = 1'b0;
    address    = '0;
    byteenable = '0;
    writedata  = '0;
    n_checks   = 0;
    n_errors   = 0;
    model_reset();

    apply_reset();

`ifdef ONCHIP_MEM_CLEAR_EN
    // Clear length, then every word reads back as zero.
    measure_clear("clear_len", 4 * DEPTH);
    for (int a = 0; a < DEPTH; a++) begin
      do_read(a);
      check("clear_zero_l1", rd_data1, '0);
    end
    idle();
    idle();

    // Interrupt the clear half-way; it must restart and run a full pass.
    apply_reset();
    measure_clear("clear_partial", 8);
    apply_reset();
    step(1'b0, 1'b0, 1'b0, 0, 0, '0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 0, 0, '0, 1'b0);
    measure_clear("clear_restart_len", 4 * DEPTH);
`endif

    // Fill the array so every later read has a known expectation.
    for (int a = 0; a < DEPTH; a++) do_write(a, $urandom, 'hF);

    // Full-word write then read.
    do_write(5, 32'hDEADBEEF, 'hF);
    do_read(5);
    check("rd5_valid_l1", DW'(rd_valid1), 32'd1);
    check("rd5_data_l1",  rd_data1, 32'hDEADBEEF);
    idle();
    check("rd5_data_l2",  rd_data2, 32'hDEADBEEF);

    // Byte-enable merge.
    do_write(5, 32'h11223344, 'h5);
    do_read(5);
    check("merge_l1", rd_data1, 32'hDE22BE44);
    idle();
    check("merge_l2", rd_data2, 32'hDE22BE44);

    // Back-to-back reads at full throughput.
    do_write(0, 32'hA0, 'hF);
    do_write(1, 32'hA1, 'hF);
    do_write(2, 32'hA2, 'hF);
    do_read(0);
    check("b2b_l1_0", rd_data1, 32'hA0);
    do_read(1);
    check("b2b_l2_0", rd_data2, 32'hA0);
    check("b2b_l1_1", rd_data1, 32'hA1);
    do_read(2);
    check("b2b_l2_1", rd_data2, 32'hA1);
    idle();
    check("b2b_l2_2", rd_data2, 32'hA2);
    check("b2b_l2_2v", DW'(rd_valid2), 32'd1);
    idle();

    // Read and write together: the write lands, the read is dropped.
    step(1'b1, 1'b1, 1'b1, 7, 'hF, 32'h55, 1'b1);
    check("rw_drop_l1", DW'(rd_valid1), 32'd0);
    idle();
    check("rw_drop_l2", DW'(rd_valid2), 32'd0);
    do_read(7);
    check("rw_data_l1", rd_data1, 32'h55);
    idle();

    // Clock enable low for three cycles with a read in flight.
    do_write(3, 32'hCAFEF00D, 'hF);
    do_read(3);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 3, 0, '0, 1'b0);
    idle();
    check("freeze_l2_valid", DW'(rd_valid2), 32'd1);
    check("freeze_l2_data",  rd_data2, 32'hCAFEF00D);
    idle();

    // Reset while a latency-2 read is in flight.
    do_read(0);
    apply_reset();
    check("rst_flight_data_l2", rd_data2, '0);
    for (int i = 0; i < CLEAR_WORDS + 4; i++) idle();

    // Refill and run randomised traffic against the model.
    for (int a = 0; a < DEPTH; a++) do_write(a, $urandom, 'hF);
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 7) != 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 3) == 0, int'($urandom_range(0, DEPTH - 1)),
           int'($urandom_range(0, (1 << BW) - 1)), $urandom,
           $urandom_range(0, 5) != 0);
    end
    for (int i = 0; i < 3; i++) idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
